// File: rtl/ap_status_monitor.sv
// ----------------------------------------------------------------------------
// ap_status_monitor
//
// Multi-channel observer for HLS block-level handshakes. Each channel tracks
// one outstanding transaction (IDLE -> BUSY -> optional HOLD) and keeps
// saturating counters: invocations, ready pulses, completions, busy cycles,
// output stalls, and last/min/max latency. Any counter of any channel can be
// read through a registered single-port readout.
//
// Ports
//   clock        rising-edge clock for all logic
//   reset        synchronous, active-low reset
//   ap_start     per-channel ap_start
//   ap_ready     per-channel ap_ready
//   ap_done      per-channel ap_done
//   ap_continue  per-channel ap_continue (tie 1 when the block has none)
//   finish       freeze channel state, counters and err while high
//   clr          synchronous clear of channel state, counters and err
//   rd_en        readout request
//   rd_ch        channel to read (values >= N_CH read as 0)
//   rd_sel       0 start, 1 ready, 2 done, 3 busy, 4 stall,
//                5 lat_last, 6 lat_min, 7 lat_max
//   rd_valid     readout data valid, one cycle after rd_en
//   rd_data      readout value, holds between reads
//   err          sticky protocol-error flag (ap_done with nothing started)
//   busy         channel is in BUSY
// ----------------------------------------------------------------------------
module ap_status_monitor #(
   parameter int N_CH  = 16,
   parameter int CNT_W = 32,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_CH-1:0]   ap_start,
   input  logic [N_CH-1:0]   ap_ready,
   input  logic [N_CH-1:0]   ap_done,
   input  logic [N_CH-1:0]   ap_continue,
   input  logic              finish,
   input  logic              clr,
   input  logic              rd_en,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [2:0]        rd_sel,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic [N_CH-1:0]   err,
   output logic [N_CH-1:0]   busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // Counter bank seen by the readout mux, indexed [channel][rd_sel].
   logic [CNT_W-1:0] cnt_all [N_CH][8];

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_q;
      logic [CNT_W-1:0] start_cnt_q, ready_cnt_q, done_cnt_q, bsy_cnt_q, stall_cnt_q;
      logic [CNT_W-1:0] lat_q, lat_last_q, lat_min_q, lat_max_q;
      logic             err_q;
      logic             rec_en;
      logic [CNT_W-1:0] rec_val;

      // A latency is recorded on the cycle ap_done closes a transaction.
      always_comb begin
         rec_en  = 1'b0;
         rec_val = CNT_ONE;
         if (state_q == ST_IDLE && ap_start[gi] && ap_done[gi]) begin
            rec_en = 1'b1;
         end else if (state_q == ST_BUSY && ap_done[gi]) begin
            rec_en  = 1'b1;
            rec_val = sat_inc(lat_q);
         end
      end

      always_ff @(posedge clock) begin
         if (!reset || clr) begin
            state_q     <= ST_IDLE;
            start_cnt_q <= '0;
            ready_cnt_q <= '0;
            done_cnt_q  <= '0;
            bsy_cnt_q   <= '0;
            stall_cnt_q <= '0;
            lat_q       <= '0;
            lat_last_q  <= '0;
            lat_min_q   <= CNT_MAX;
            lat_max_q   <= '0;
            err_q       <= 1'b0;
         end else if (!finish) begin
            if (ap_ready[gi]) begin
               ready_cnt_q <= sat_inc(ready_cnt_q);
            end
            if (rec_en) begin
               lat_last_q <= rec_val;
               if (rec_val < lat_min_q) lat_min_q <= rec_val;
               if (rec_val > lat_max_q) lat_max_q <= rec_val;
            end
            case (state_q)
               ST_IDLE: begin
                  if (ap_start[gi]) begin
                     start_cnt_q <= sat_inc(start_cnt_q);
                     bsy_cnt_q   <= sat_inc(bsy_cnt_q);
                     if (ap_done[gi]) begin
                        // Zero-latency block: done in the start cycle.
                        if (ap_continue[gi]) done_cnt_q <= sat_inc(done_cnt_q);
                        else                 state_q    <= ST_HOLD;
                     end else begin
                        state_q <= ST_BUSY;
                        lat_q   <= CNT_ONE;
                     end
                  end else if (ap_done[gi]) begin
                     // Completion without an invocation is a protocol error.
                     err_q <= 1'b1;
                     if (ap_continue[gi]) done_cnt_q <= sat_inc(done_cnt_q);
                  end
               end
               ST_BUSY: begin
                  bsy_cnt_q <= sat_inc(bsy_cnt_q);
                  if (ap_done[gi]) begin
                     if (ap_continue[gi]) begin
                        done_cnt_q <= sat_inc(done_cnt_q);
                        state_q    <= ST_IDLE;
                     end else begin
                        state_q <= ST_HOLD;
                     end
                  end else begin
                     lat_q <= sat_inc(lat_q);
                  end
               end
               ST_HOLD: begin
                  if (ap_continue[gi]) begin
                     done_cnt_q <= sat_inc(done_cnt_q);
                     state_q    <= ST_IDLE;
                  end else begin
                     stall_cnt_q <= sat_inc(stall_cnt_q);
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end

      assign err[gi]  = err_q;
      assign busy[gi] = (state_q == ST_BUSY);

      assign cnt_all[gi][0] = start_cnt_q;
      assign cnt_all[gi][1] = ready_cnt_q;
      assign cnt_all[gi][2] = done_cnt_q;
      assign cnt_all[gi][3] = bsy_cnt_q;
      assign cnt_all[gi][4] = stall_cnt_q;
      assign cnt_all[gi][5] = lat_last_q;
      assign cnt_all[gi][6] = lat_min_q;
      assign cnt_all[gi][7] = lat_max_q;
   end

   // Readout: selects from the registered counters, so a read in the same
   // cycle as an update returns the pre-update value. Out-of-range channels
   // fall through to zero.
   logic [CNT_W-1:0] rd_mux;
   logic             rd_valid_q;
   logic [CNT_W-1:0] rd_data_q;

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (32'(rd_ch) == i) rd_mux = cnt_all[i][rd_sel];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) rd_data_q <= rd_mux;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ap_status_monitor.sv
// ----------------------------------------------------------------------------
// tb_ap_status_monitor
//
// Bench for ap_status_monitor. A 6-channel, 32-bit instance is checked every
// cycle against a transaction-level model of the handshake rules, and pinned
// with hand-computed readouts. A 1-channel, 4-bit instance exercises counter
// saturation and clr/ap_done collision with literal expectations.
// ----------------------------------------------------------------------------
module tb_ap_status_monitor;

   localparam int N = 6;
   localparam longint unsigned MAXV = 64'hFFFF_FFFF;
   localparam int S_START = 0, S_RDY = 1, S_DONE = 2, S_BSY = 3,
                  S_STALL = 4, S_LAST = 5, S_MIN = 6, S_MAX = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  start, ready, done, cont;
   logic          finish, clr, rd_en;
   logic [2:0]    rd_ch, rd_sel;
   logic          rd_valid;
   logic [31:0]   rd_data;
   logic [N-1:0]  err, busy;

   logic [0:0]    s_start, s_ready, s_done, s_cont;
   logic          s_finish, s_clr, s_rd_en;
   logic [0:0]    s_rd_ch;
   logic [2:0]    s_rd_sel;
   logic          s_rd_valid;
   logic [3:0]    s_rd_data;
   logic [0:0]    s_err, s_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ap_status_monitor #(.N_CH(N), .CNT_W(32)) dut (
      .clock(clk), .reset(rst_n),
      .ap_start(start), .ap_ready(ready), .ap_done(done), .ap_continue(cont),
      .finish(finish), .clr(clr), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
      .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .busy(busy)
   );

   ap_status_monitor #(.N_CH(1), .CNT_W(4)) dut_s (
      .clock(clk), .reset(rst_n),
      .ap_start(s_start), .ap_ready(s_ready), .ap_done(s_done), .ap_continue(s_cont),
      .finish(s_finish), .clr(s_clr), .rd_en(s_rd_en), .rd_ch(s_rd_ch), .rd_sel(s_rd_sel),
      .rd_valid(s_rd_valid), .rd_data(s_rd_data), .err(s_err), .busy(s_busy)
   );

   // ---------------- transaction-level model ----------------
   longint unsigned m_cnt [N][8];
   longint unsigned m_run [N];
   bit              m_open [N];   // transaction started, ap_done not yet seen
   bit              m_wait [N];   // ap_done seen, waiting for ap_continue
   bit              m_err  [N];
   bit              exp_valid = 1'b0;
   longint unsigned exp_data  = 0;

   function automatic longint unsigned inc(input longint unsigned v);
      return (v >= MAXV) ? MAXV : v + 1;
   endfunction

   task automatic m_clear();
      for (int c = 0; c < N; c++) begin
         for (int s = 0; s < 8; s++) m_cnt[c][s] = (s == S_MIN) ? MAXV : 0;
         m_run[c] = 0; m_open[c] = 0; m_wait[c] = 0; m_err[c] = 0;
      end
   endtask

   task automatic m_rec(input int c, input longint unsigned l);
      m_cnt[c][S_LAST] = l;
      if (l < m_cnt[c][S_MIN]) m_cnt[c][S_MIN] = l;
      if (l > m_cnt[c][S_MAX]) m_cnt[c][S_MAX] = l;
   endtask

   task automatic m_chan(input int c);
      if (ready[c]) m_cnt[c][S_RDY] = inc(m_cnt[c][S_RDY]);
      if (m_open[c]) begin
         m_cnt[c][S_BSY] = inc(m_cnt[c][S_BSY]);
         if (done[c]) begin
            m_rec(c, inc(m_run[c]));
            m_open[c] = 0;
            if (cont[c]) m_cnt[c][S_DONE] = inc(m_cnt[c][S_DONE]);
            else         m_wait[c] = 1;
         end else begin
            m_run[c] = inc(m_run[c]);
         end
      end else if (m_wait[c]) begin
         if (cont[c]) begin
            m_cnt[c][S_DONE] = inc(m_cnt[c][S_DONE]);
            m_wait[c] = 0;
         end else begin
            m_cnt[c][S_STALL] = inc(m_cnt[c][S_STALL]);
         end
      end else if (start[c]) begin
         m_cnt[c][S_START] = inc(m_cnt[c][S_START]);
         m_cnt[c][S_BSY]   = inc(m_cnt[c][S_BSY]);
         if (done[c]) begin
            m_rec(c, 1);
            if (cont[c]) m_cnt[c][S_DONE] = inc(m_cnt[c][S_DONE]);
            else         m_wait[c] = 1;
         end else begin
            m_open[c] = 1;
            m_run[c]  = 1;
         end
      end else if (done[c]) begin
         m_err[c] = 1;
         if (cont[c]) m_cnt[c][S_DONE] = inc(m_cnt[c][S_DONE]);
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_clear();
         exp_valid = 0;
         exp_data  = 0;
      end else begin
         exp_valid = rd_en;
         if (rd_en) begin
            int c;
            c = int'(rd_ch);
            exp_data = (c < N) ? m_cnt[c][rd_sel] : 0;
         end
         if (clr) m_clear();
         else if (!finish) for (int c = 0; c < N; c++) m_chan(c);
      end
   end

   function automatic logic [N-1:0] m_busy_vec();
      logic [N-1:0] v;
      for (int c = 0; c < N; c++) v[c] = m_open[c];
      return v;
   endfunction

   function automatic logic [N-1:0] m_err_vec();
      logic [N-1:0] v;
      for (int c = 0; c < N; c++) v[c] = m_err[c];
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("busy", {58'd0, busy}, {58'd0, m_busy_vec()});
         chk("err", {58'd0, err}, {58'd0, m_err_vec()});
         chk("rd_valid", {63'd0, rd_valid}, {63'd0, exp_valid});
         if (exp_valid) chk("rd_data", {32'd0, rd_data}, exp_data);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic rd(input int ch, input int sel, input logic [63:0] expv, input string name);
      @(negedge clk);
      rd_en = 1'b1; rd_ch = ch[2:0]; rd_sel = sel[2:0];
      @(negedge clk);
      rd_en = 1'b0;
      chk({name, "_valid"}, {63'd0, rd_valid}, 64'd1);
      chk(name, {32'd0, rd_data}, expv);
      $display("read ch%0d sel%0d -> %0h (%s)", ch, sel, rd_data, name);
   endtask

   task automatic srd(input int ch, input int sel, input logic [63:0] expv, input string name);
      @(negedge clk);
      s_rd_en = 1'b1; s_rd_ch = ch[0:0]; s_rd_sel = sel[2:0];
      @(negedge clk);
      s_rd_en = 1'b0;
      chk({name, "_valid"}, {63'd0, s_rd_valid}, 64'd1);
      chk(name, {60'd0, s_rd_data}, expv);
      $display("small read ch%0d sel%0d -> %0h (%s)", ch, sel, s_rd_data, name);
   endtask

   // One transaction on channel ch with latency l, then h stall cycles.
   task automatic txn(input int ch, input int l, input int h);
      @(negedge clk);
      start[ch] = 1'b1;
      if (l == 1) begin done[ch] = 1'b1; cont[ch] = (h == 0); end
      @(negedge clk);
      start[ch] = 1'b0;
      if (l > 1) begin
         repeat (l - 2) @(negedge clk);
         done[ch] = 1'b1; cont[ch] = (h == 0);
         @(negedge clk);
      end
      done[ch] = 1'b0;
      if (h > 0) begin
         repeat (h) @(negedge clk);
         cont[ch] = 1'b1;
         @(negedge clk);
      end
      $display("txn ch%0d lat %0d stall %0d", ch, l, h);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      start = '0; ready = '0; done = '0; cont = '1;
      finish = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
      s_start = '0; s_ready = '0; s_done = '0; s_cont = '1;
      s_finish = 1'b0; s_clr = 1'b0; s_rd_en = 1'b0; s_rd_ch = '0; s_rd_sel = '0;

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_busy", {58'd0, busy}, 64'd0);
      chk("rst_err", {58'd0, err}, 64'd0);
      chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
      rd(0, S_MIN, 64'hFFFF_FFFF, "rst_min");
      for (int s = 0; s < 8; s++) if (s != S_MIN) rd(0, s, 0, "rst_zero");

      // Single transaction, latency 6.
      txn(3, 6, 0);
      rd(3, S_START, 1, "ch3_start");
      rd(3, S_DONE, 1, "ch3_done");
      rd(3, S_BSY, 6, "ch3_busy");
      rd(3, S_LAST, 6, "ch3_last");
      rd(3, S_MIN, 6, "ch3_min");
      rd(3, S_MAX, 6, "ch3_max");
      rd(3, S_STALL, 0, "ch3_stall");

      // Three transactions: latencies 4, 2, 9.
      txn(1, 4, 0);
      txn(1, 2, 0);
      txn(1, 9, 0);
      rd(1, S_LAST, 9, "ch1_last");
      rd(1, S_MIN, 2, "ch1_min");
      rd(1, S_MAX, 9, "ch1_max");
      rd(1, S_DONE, 3, "ch1_done");
      rd(1, S_BSY, 15, "ch1_busy");

      // Output stall: 3 cycles of ap_continue=0 after ap_done.
      txn(0, 3, 3);
      rd(0, S_STALL, 3, "ch0_stall");
      rd(0, S_DONE, 1, "ch0_done");
      rd(0, S_LAST, 3, "ch0_last");
      chk("ch0_idle", {63'd0, busy[0]}, 64'd0);

      // ap_done without ap_start: sticky error.
      @(negedge clk); done[2] = 1'b1;
      @(negedge clk); done[2] = 1'b0;
      chk("ch2_err", {63'd0, err[2]}, 64'd1);
      repeat (5) @(negedge clk);
      chk("ch2_err_sticky", {63'd0, err[2]}, 64'd1);
      rd(2, S_DONE, 1, "ch2_done");

      // Zero-latency blocks, with and without output stall.
      txn(4, 1, 0);
      txn(5, 1, 2);
      rd(4, S_LAST, 1, "ch4_last");
      rd(5, S_STALL, 2, "ch5_stall");
      rd(5, S_DONE, 1, "ch5_done");

      // ap_ready pulses on ch1 and ch2.
      @(negedge clk); ready = 6'b000110;
      repeat (3) @(negedge clk);
      ready = '0;
      rd(1, S_RDY, 3, "ch1_ready");

      // Back-to-back reads, one result per cycle.
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         rd_en = 1'b1; rd_ch = 3'd1; rd_sel = s[2:0];
      end
      @(negedge clk); rd_en = 1'b0;

      // Read in the same cycle as an update returns the old value.
      @(negedge clk); ready[1] = 1'b1; rd_en = 1'b1; rd_ch = 3'd1; rd_sel = 3'(S_RDY);
      @(negedge clk); ready[1] = 1'b0; rd_en = 1'b0;
      chk("same_cycle_read", {32'd0, rd_data}, 64'd3);
      rd(1, S_RDY, 4, "ch1_ready_after");

      // clr in the same cycle as ap_done; a read in that cycle still completes.
      @(negedge clk); start[3] = 1'b1;
      @(negedge clk); start[3] = 1'b0;
      @(negedge clk);
      @(negedge clk); done[3] = 1'b1; clr = 1'b1; rd_en = 1'b1; rd_ch = 3'd1; rd_sel = 3'(S_START);
      @(negedge clk); done[3] = 1'b0; clr = 1'b0; rd_en = 1'b0;
      chk("clr_read_valid", {63'd0, rd_valid}, 64'd1);
      chk("clr_read_data", {32'd0, rd_data}, 64'd3);
      chk("clr_err", {58'd0, err}, 64'd0);
      chk("clr_busy", {58'd0, busy}, 64'd0);
      rd(3, S_DONE, 0, "clr_done");
      rd(3, S_START, 0, "clr_start");
      rd(1, S_BSY, 0, "clr_busy1");
      rd(3, S_MIN, 64'hFFFF_FFFF, "clr_min");

      // finish freezes a BUSY channel while readout keeps working.
      @(negedge clk); start[3] = 1'b1;
      @(negedge clk); start[3] = 1'b0; finish = 1'b1; ready[3] = 1'b1;
      rd(3, S_BSY, 1, "fin_busy");
      rd(3, S_RDY, 0, "fin_ready");
      rd(6, S_START, 0, "out_of_range");
      repeat (3) @(negedge clk);
      finish = 1'b0; ready[3] = 1'b0;
      @(negedge clk); done[3] = 1'b1;
      @(negedge clk); done[3] = 1'b0;
      rd(3, S_LAST, 3, "fin_last");
      rd(3, S_BSY, 3, "fin_busy_after");

      // Small instance: 4-bit counters saturate at 15.
      @(negedge clk); s_ready = 1'b1;
      repeat (20) @(negedge clk);
      s_ready = 1'b0;
      srd(0, S_RDY, 15, "s_ready_sat");
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      repeat (20) @(negedge clk);
      s_done = 1'b1;
      @(negedge clk); s_done = 1'b0;
      srd(0, S_BSY, 15, "s_busy_sat");
      srd(0, S_LAST, 15, "s_last_sat");
      srd(0, S_MIN, 15, "s_min_sat");
      srd(0, S_START, 1, "s_start");
      srd(0, S_DONE, 1, "s_done");
      srd(1, S_RDY, 0, "s_out_of_range");
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      @(negedge clk); s_done = 1'b1; s_clr = 1'b1;
      @(negedge clk); s_done = 1'b0; s_clr = 1'b0;
      chk("s_clr_busy", {63'd0, s_busy}, 64'd0);
      srd(0, S_DONE, 0, "s_clr_done");
      srd(0, S_RDY, 0, "s_clr_ready");
      srd(0, S_MIN, 15, "s_clr_min");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
